// File: rtl/housekeeping_spi_scheduler.sv
// housekeeping_spi_scheduler
//
// Purpose: shares the housekeeping SPI master between DAC write requests and
// ADC read requests. Each granted request is serialised into a byte frame on
// the MOSI stream. select_adc is switched with a guard interval whenever the
// polarity changes. ADC reply bytes from the MISO stream are assembled into a
// 16-bit result, and a missing reply byte is reported as a timeout.
//
// Optional feature (macro HK_AUTO_POLL_EN): a periodic internal ADC read that
// scans the channels set in poll_mask round-robin. When the macro is not
// defined, the poll_* ports are ignored.
//
// Ports:
//   clk_core, clk_core_rst          clock, synchronous active-high reset
//   dac_req_*                       DAC write request (valid/ready, channel, code)
//   adc_req_*                       ADC read request (valid/ready, channel)
//   adc_rsp_*                       one-cycle result pulse (channel, data, timeout)
//   select_adc                      SPI wrapper polarity, 1 for ADC frames
//   mosi_m_axis_*                   frame bytes to the MOSI FIFO
//   miso_s_axis_*                   reply bytes from the MISO FIFO (always ready)
//   poll_enable/period/mask         auto-poll control
//   busy                            FSM is not idle
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | arbitrate requesters, register the winning request
// S_GUARD    | select_adc just changed, hold off for GUARD_CYCLES
// S_SEND     | offer frame bytes on MOSI, one byte per accepted beat
// S_WAIT_RSP | collect two ADC reply bytes, watch the per-byte timeout
// S_RESPOND  | single-cycle adc_rsp_valid pulse

module housekeeping_spi_scheduler #(
  parameter int unsigned GUARD_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned POLL_DIV_W     = 24
) (
  input  logic                  clk_core,
  input  logic                  clk_core_rst,
  input  logic                  dac_req_valid,
  output logic                  dac_req_ready,
  input  logic [3:0]            dac_req_channel,
  input  logic [15:0]           dac_req_code,
  input  logic                  adc_req_valid,
  output logic                  adc_req_ready,
  input  logic [3:0]            adc_req_channel,
  output logic                  adc_rsp_valid,
  output logic [3:0]            adc_rsp_channel,
  output logic [15:0]           adc_rsp_data,
  output logic                  adc_rsp_timeout,
  output logic                  select_adc,
  output logic [7:0]            mosi_m_axis_tdata,
  output logic                  mosi_m_axis_tvalid,
  output logic                  mosi_m_axis_tlast,
  input  logic                  mosi_m_axis_tready,
  input  logic [7:0]            miso_s_axis_tdata,
  input  logic                  miso_s_axis_tvalid,
  output logic                  miso_s_axis_tready,
  input  logic                  poll_enable,
  input  logic [POLL_DIV_W-1:0] poll_period,
  input  logic [15:0]           poll_mask,
  output logic                  busy
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_SEND,
    S_WAIT_RSP,
    S_RESPOND
  } state_t;

  state_t        r_state;
  logic          r_last_adc;
  logic          r_select_adc;
  logic          r_is_adc;
  logic [3:0]    r_ch;
  logic [15:0]   r_code;
  logic [1:0]    r_idx;
  logic [GW-1:0] r_guard;
  logic [TW-1:0] r_timer;
  logic          r_rx_cnt;
  logic [15:0]   r_rsp_data;
  logic          r_rsp_timeout;

  logic          w_dac_win;
  logic          w_adc_win;
  logic          w_poll_win;
  logic          w_grant;
  logic          w_grant_adc;
  logic [3:0]    w_grant_ch;
  logic          w_poll_pend;
  logic [3:0]    w_poll_ch;
  logic [7:0]    w_tdata;
  logic          w_last;
  logic          w_beat;

  // When both external requesters are valid, the one that was not served last wins.
  // The internal poll request is only taken when neither external requester is valid.
  always_comb begin
    w_dac_win  = 1'b0;
    w_adc_win  = 1'b0;
    w_poll_win = 1'b0;
    if (r_state == S_IDLE) begin
      if (dac_req_valid && adc_req_valid) begin
        if (r_last_adc) w_dac_win = 1'b1;
        else            w_adc_win = 1'b1;
      end else if (dac_req_valid) begin
        w_dac_win = 1'b1;
      end else if (adc_req_valid) begin
        w_adc_win = 1'b1;
      end else if (w_poll_pend) begin
        w_poll_win = 1'b1;
      end
    end
  end

  assign w_grant     = w_dac_win | w_adc_win | w_poll_win;
  assign w_grant_adc = w_adc_win | w_poll_win;
  assign w_grant_ch  = w_dac_win ? dac_req_channel :
                       w_adc_win ? adc_req_channel : w_poll_ch;

  always_comb begin
    w_tdata = 8'h00;
    w_last  = 1'b0;
    if (r_is_adc) begin
      w_last = (r_idx == 2'd1);
      if (r_idx == 2'd0) w_tdata = {4'h1, r_ch};
    end else begin
      w_last = (r_idx == 2'd2);
      case (r_idx)
        2'd0:    w_tdata = {4'h3, r_ch};
        2'd1:    w_tdata = r_code[15:8];
        default: w_tdata = r_code[7:0];
      endcase
    end
  end

  assign w_beat = (r_state == S_SEND) && mosi_m_axis_tready;

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      r_state       <= S_IDLE;
      r_last_adc    <= 1'b1;
      r_select_adc  <= 1'b0;
      r_is_adc      <= 1'b0;
      r_ch          <= 4'h0;
      r_code        <= 16'h0000;
      r_idx         <= 2'd0;
      r_guard       <= '0;
      r_timer       <= '0;
      r_rx_cnt      <= 1'b0;
      r_rsp_data    <= 16'h0000;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_is_adc   <= w_grant_adc;
            r_ch       <= w_grant_ch;
            r_code     <= dac_req_code;
            r_idx      <= 2'd0;
            r_last_adc <= w_grant_adc;
            if (w_grant_adc != r_select_adc) begin
              r_select_adc <= w_grant_adc;
              if (GUARD_CYCLES == 0) begin
                r_state <= S_SEND;
              end else begin
                r_guard <= GW'(GUARD_CYCLES - 1);
                r_state <= S_GUARD;
              end
            end else begin
              r_state <= S_SEND;
            end
          end
        end
        S_GUARD: begin
          if (r_guard == '0) r_state <= S_SEND;
          else               r_guard <= r_guard - GW'(1);
        end
        S_SEND: begin
          if (w_beat) begin
            if (!w_last) begin
              r_idx <= r_idx + 2'd1;
            end else if (r_is_adc) begin
              r_timer  <= TW'(TIMEOUT_CYCLES - 1);
              r_rx_cnt <= 1'b0;
              r_state  <= S_WAIT_RSP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_RSP: begin
          if (miso_s_axis_tvalid) begin
            r_timer <= TW'(TIMEOUT_CYCLES - 1);
            if (!r_rx_cnt) begin
              r_rsp_data[15:8] <= miso_s_axis_tdata;
              r_rx_cnt         <= 1'b1;
            end else begin
              r_rsp_data[7:0] <= miso_s_axis_tdata;
              r_rsp_timeout   <= 1'b0;
              r_state         <= S_RESPOND;
            end
          end else if (r_timer == '0) begin
            r_rsp_data    <= 16'h0000;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESPOND;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef HK_AUTO_POLL_EN
  logic [POLL_DIV_W-1:0] r_poll_cnt;
  logic                  r_poll_pend;
  logic [3:0]            r_poll_ch;
  logic [3:0]            r_poll_ptr;
  logic                  w_scan_hit;
  logic [3:0]            w_scan_ch;
  logic [3:0]            w_scan_idx;

  // First set mask bit at or after the round-robin pointer, wrapping at 16.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_ch  = 4'h0;
    w_scan_idx = 4'h0;
    for (int k = 0; k < 16; k++) begin
      w_scan_idx = r_poll_ptr + 4'(k);
      if (!w_scan_hit && poll_mask[w_scan_idx]) begin
        w_scan_hit = 1'b1;
        w_scan_ch  = w_scan_idx;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      r_poll_cnt  <= '0;
      r_poll_pend <= 1'b0;
      r_poll_ch   <= 4'h0;
      r_poll_ptr  <= 4'h0;
    end else begin
      if (w_poll_win) r_poll_pend <= 1'b0;
      if (!poll_enable || (poll_period == '0) || (poll_mask == 16'h0000)) begin
        r_poll_cnt <= '0;
      end else if (r_poll_cnt >= poll_period - POLL_DIV_W'(1)) begin
        r_poll_cnt <= '0;
        // An expiry while a poll is still pending is dropped, not queued.
        if (!r_poll_pend && w_scan_hit) begin
          r_poll_pend <= 1'b1;
          r_poll_ch   <= w_scan_ch;
          r_poll_ptr  <= w_scan_ch + 4'd1;
        end
      end else begin
        r_poll_cnt <= r_poll_cnt + POLL_DIV_W'(1);
      end
    end
  end

  assign w_poll_pend = r_poll_pend;
  assign w_poll_ch   = r_poll_ch;
`else
  logic w_poll_unused;
  assign w_poll_unused = ^{poll_enable, poll_period, poll_mask};
  assign w_poll_pend   = 1'b0;
  assign w_poll_ch     = 4'h0;
`endif

  assign dac_req_ready      = w_dac_win;
  assign adc_req_ready      = w_adc_win;
  assign adc_rsp_valid      = (r_state == S_RESPOND);
  assign adc_rsp_channel    = adc_rsp_valid ? r_ch : 4'h0;
  assign adc_rsp_data       = adc_rsp_valid ? r_rsp_data : 16'h0000;
  assign adc_rsp_timeout    = adc_rsp_valid & r_rsp_timeout;
  assign select_adc         = r_select_adc;
  assign mosi_m_axis_tvalid = (r_state == S_SEND);
  assign mosi_m_axis_tdata  = mosi_m_axis_tvalid ? w_tdata : 8'h00;
  assign mosi_m_axis_tlast  = mosi_m_axis_tvalid & w_last;
  assign miso_s_axis_tready = 1'b1;
  assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_housekeeping_spi_scheduler.sv
// tb_housekeeping_spi_scheduler
//
// Directed bench for housekeeping_spi_scheduler (GUARD_CYCLES=64,
// TIMEOUT_CYCLES=16, auto-poll not built). Inputs change and outputs are
// sampled on the falling edge of clk_core.

module tb_housekeeping_spi_scheduler;

  logic        clk_core = 1'b0;
  logic        clk_core_rst;
  logic        dac_req_valid;
  logic        dac_req_ready;
  logic [3:0]  dac_req_channel;
  logic [15:0] dac_req_code;
  logic        adc_req_valid;
  logic        adc_req_ready;
  logic [3:0]  adc_req_channel;
  logic        adc_rsp_valid;
  logic [3:0]  adc_rsp_channel;
  logic [15:0] adc_rsp_data;
  logic        adc_rsp_timeout;
  logic        select_adc;
  logic [7:0]  mosi_m_axis_tdata;
  logic        mosi_m_axis_tvalid;
  logic        mosi_m_axis_tlast;
  logic        mosi_m_axis_tready;
  logic [7:0]  miso_s_axis_tdata;
  logic        miso_s_axis_tvalid;
  logic        miso_s_axis_tready;
  logic        poll_enable;
  logic [23:0] poll_period;
  logic [15:0] poll_mask;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_b [0:3];
  logic [3:0] cap_l;
  int         cap_n;
  int         cap_lat;
  int         n_pulse;
  int         w;

  always #5 clk_core = ~clk_core;

  housekeeping_spi_scheduler #(
    .GUARD_CYCLES   (64),
    .TIMEOUT_CYCLES (16),
    .POLL_DIV_W     (24)
  ) dut (
    .clk_core           (clk_core),
    .clk_core_rst       (clk_core_rst),
    .dac_req_valid      (dac_req_valid),
    .dac_req_ready      (dac_req_ready),
    .dac_req_channel    (dac_req_channel),
    .dac_req_code       (dac_req_code),
    .adc_req_valid      (adc_req_valid),
    .adc_req_ready      (adc_req_ready),
    .adc_req_channel    (adc_req_channel),
    .adc_rsp_valid      (adc_rsp_valid),
    .adc_rsp_channel    (adc_rsp_channel),
    .adc_rsp_data       (adc_rsp_data),
    .adc_rsp_timeout    (adc_rsp_timeout),
    .select_adc         (select_adc),
    .mosi_m_axis_tdata  (mosi_m_axis_tdata),
    .mosi_m_axis_tvalid (mosi_m_axis_tvalid),
    .mosi_m_axis_tlast  (mosi_m_axis_tlast),
    .mosi_m_axis_tready (mosi_m_axis_tready),
    .miso_s_axis_tdata  (miso_s_axis_tdata),
    .miso_s_axis_tvalid (miso_s_axis_tvalid),
    .miso_s_axis_tready (miso_s_axis_tready),
    .poll_enable        (poll_enable),
    .poll_period        (poll_period),
    .poll_mask          (poll_mask),
    .busy               (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    clk_core_rst = 1'b1;
    repeat (3) @(negedge clk_core);
    clk_core_rst = 1'b0;
  endtask

  // Raise a request, wait for its ready, let the handshake edge pass, drop valid.
  task automatic issue(input bit is_adc, input logic [3:0] ch, input logic [15:0] code);
    int k;
    if (is_adc) begin
      adc_req_valid = 1'b1; adc_req_channel = ch;
    end else begin
      dac_req_valid = 1'b1; dac_req_channel = ch; dac_req_code = code;
    end
    #1;
    k = 0;
    while (!(is_adc ? adc_req_ready : dac_req_ready) && k < 20) begin
      @(negedge clk_core); k++;
    end
    chk(is_adc ? "adc_grant" : "dac_grant", {31'd0, (is_adc ? adc_req_ready : dac_req_ready)}, 32'd1);
    @(posedge clk_core);
    @(negedge clk_core);
    adc_req_valid = 1'b0;
    dac_req_valid = 1'b0;
  endtask

  // Capture n accepted MOSI bytes; toggle=1 stalls tready on even cycles.
  task automatic grab(input int n, input bit toggle);
    int c;
    c = 0; cap_n = 0; cap_lat = -1; cap_l = 4'b0000;
    while (cap_n < n && c < 300) begin
      mosi_m_axis_tready = toggle ? c[0] : 1'b1;
      if (mosi_m_axis_tvalid) begin
        if (cap_lat < 0) cap_lat = c;
        if (mosi_m_axis_tready) begin
          cap_b[cap_n] = mosi_m_axis_tdata;
          cap_l[cap_n] = mosi_m_axis_tlast;
          cap_n++;
        end
      end
      @(negedge clk_core); c++;
    end
    mosi_m_axis_tready = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int n, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input int lat);
    chk({tag, "_count"}, cap_n, n);
    chk({tag, "_lat"}, cap_lat, lat);
    chk({tag, "_b0"}, {24'd0, cap_b[0]}, {24'd0, e0});
    chk({tag, "_b1"}, {24'd0, cap_b[1]}, {24'd0, e1});
    if (n == 3) chk({tag, "_b2"}, {24'd0, cap_b[2]}, {24'd0, e2});
    chk({tag, "_tlast"}, {28'd0, cap_l}, (n == 3) ? 32'h4 : 32'h2);
  endtask

  task automatic miso_byte(input logic [7:0] b);
    miso_s_axis_tvalid = 1'b1; miso_s_axis_tdata = b;
    @(negedge clk_core);
    miso_s_axis_tvalid = 1'b0; miso_s_axis_tdata = 8'h00;
  endtask

  initial begin
    clk_core_rst = 1'b1;
    dac_req_valid = 1'b0; dac_req_channel = 4'h0; dac_req_code = 16'h0000;
    adc_req_valid = 1'b0; adc_req_channel = 4'h0;
    mosi_m_axis_tready = 1'b1;
    miso_s_axis_tdata = 8'h00; miso_s_axis_tvalid = 1'b0;
    poll_enable = 1'b0; poll_period = 24'd0; poll_mask = 16'h0000;
    @(negedge clk_core);
    do_reset();

    // Reset values
    chk("rst_outs", {busy, select_adc, mosi_m_axis_tvalid, mosi_m_axis_tlast, adc_rsp_valid,
                     adc_rsp_timeout, dac_req_ready, adc_req_ready}, 32'h0);
    chk("rst_tdata", {mosi_m_axis_tdata, adc_rsp_data, adc_rsp_channel}, 32'h0);
    chk("rst_miso_rdy", {31'd0, miso_s_axis_tready}, 32'd1);

    // DAC ch2 0xABCD, no polarity change
    issue(1'b0, 4'h2, 16'hABCD);
    chk("dac1_sel", {31'd0, select_adc}, 32'd0);
    grab(3, 1'b0);
    expect_frame("dac1", 3, 8'h32, 8'hAB, 8'hCD, 0);
    chk("dac1_idle", {30'd0, busy, select_adc}, 32'd0);

    // ADC ch5 from reset: guard, reply 0x1234
    do_reset();
    issue(1'b1, 4'h5, 16'h0000);
    chk("adc1_sel", {31'd0, select_adc}, 32'd1);
    grab(2, 1'b0);
    expect_frame("adc1", 2, 8'h15, 8'h00, 8'h00, 64);
    miso_byte(8'h12);
    miso_byte(8'h34);
    chk("adc1_rsp", {adc_rsp_valid, adc_rsp_timeout, 10'd0, adc_rsp_channel, adc_rsp_data},
        {1'b1, 1'b0, 10'd0, 4'h5, 16'h1234});
    @(negedge clk_core);
    chk("adc1_pulse", {31'd0, adc_rsp_valid}, 32'd0);

    // Both valid after reset: DAC first, then ADC after the guard
    do_reset();
    dac_req_valid = 1'b1; dac_req_channel = 4'h4; dac_req_code = 16'h5A5A;
    adc_req_valid = 1'b1; adc_req_channel = 4'h7;
    #1;
    chk("both_rdy", {30'd0, dac_req_ready, adc_req_ready}, 32'h2);
    @(posedge clk_core); @(negedge clk_core);
    dac_req_valid = 1'b0;
    chk("both_adc_wait", {31'd0, adc_req_ready}, 32'd0);
    grab(3, 1'b0);
    expect_frame("both_dac", 3, 8'h34, 8'h5A, 8'h5A, 0);
    chk("both_adc_rdy", {31'd0, adc_req_ready}, 32'd1);
    @(posedge clk_core); @(negedge clk_core);
    adc_req_valid = 1'b0;
    grab(2, 1'b0);
    expect_frame("both_adc", 2, 8'h17, 8'h00, 8'h00, 64);

    // No MISO bytes: timeout after 16 waiting cycles
    w = 0;
    while (!adc_rsp_valid && w < 100) begin
      @(negedge clk_core); w++;
    end
    chk("to_wait", w, 16);
    chk("to_rsp", {adc_rsp_valid, adc_rsp_timeout, 10'd0, adc_rsp_channel, adc_rsp_data},
        {1'b1, 1'b1, 10'd0, 4'h7, 16'h0000});
    @(negedge clk_core);
    chk("to_idle", {30'd0, adc_rsp_valid, busy}, 32'd0);

    // Next request accepted; polarity back to DAC, tready toggling
    issue(1'b0, 4'h1, 16'h00FF);
    chk("dac2_sel", {31'd0, select_adc}, 32'd0);
    grab(3, 1'b1);
    expect_frame("dac2", 3, 8'h31, 8'h00, 8'hFF, 64);

    // Same polarity: no guard, tready toggling
    issue(1'b0, 4'hF, 16'h1234);
    grab(3, 1'b1);
    expect_frame("dac3", 3, 8'h3F, 8'h12, 8'h34, 0);

    // Both valid after a DAC grant: ADC wins
    dac_req_valid = 1'b1; dac_req_channel = 4'h8; dac_req_code = 16'hFFFF;
    adc_req_valid = 1'b1; adc_req_channel = 4'h3;
    #1;
    chk("alt_rdy", {30'd0, dac_req_ready, adc_req_ready}, 32'h1);
    @(posedge clk_core); @(negedge clk_core);
    dac_req_valid = 1'b0; adc_req_valid = 1'b0;
    grab(2, 1'b0);
    expect_frame("adc3", 2, 8'h13, 8'h00, 8'h00, 64);

    // Reset during WAIT_RSP
    miso_byte(8'hAA);
    @(negedge clk_core);
    clk_core_rst = 1'b1;
    @(posedge clk_core); @(negedge clk_core);
    chk("mid_rst", {busy, select_adc, adc_rsp_valid, mosi_m_axis_tvalid}, 32'h0);
    clk_core_rst = 1'b0;
    miso_byte(8'h55);
    n_pulse = 0;
    repeat (30) begin
      if (adc_rsp_valid) n_pulse++;
      @(negedge clk_core);
    end
    chk("mid_rst_nopulse", n_pulse, 0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);

    // Fresh ADC read after the abort uses only the new reply bytes
    issue(1'b1, 4'h9, 16'h0000);
    grab(2, 1'b0);
    expect_frame("adc4", 2, 8'h19, 8'h00, 8'h00, 64);
    miso_byte(8'hBE);
    miso_byte(8'hEF);
    chk("adc4_rsp", {adc_rsp_valid, adc_rsp_timeout, 10'd0, adc_rsp_channel, adc_rsp_data},
        {1'b1, 1'b0, 10'd0, 4'h9, 16'hBEEF});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
